// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: arbitrates fetch and LSU requests onto one in-order memory bus and routes responses back
// Ports: f_req_*/f_rsp_* fetch side (read only), l_req_*/l_rsp_* LSU side, flush_i drops pending fetch
// responses, m_req_*/m_rsp_* shared bus (valid/ready requests, in-order responses), busy_o responses
// pending, proto_err_o sticky response-with-nothing-outstanding flag.
module mem_port_arbiter #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_req_valid_i,
  input  logic [31:0] f_req_addr_i,
  output logic        f_req_ready_o,
  output logic        f_rsp_valid_o,
  output logic [31:0] f_rsp_data_o,
  output logic        f_rsp_err_o,
  input  logic        l_req_valid_i,
  input  logic [31:0] l_req_addr_i,
  input  logic        l_req_we_i,
  input  logic [31:0] l_req_wdata_i,
  input  logic [3:0]  l_req_strb_i,
  output logic        l_req_ready_o,
  output logic        l_rsp_valid_o,
  output logic [31:0] l_rsp_data_o,
  output logic        l_rsp_err_o,
  input  logic        flush_i,
  output logic        m_req_valid_o,
  input  logic        m_req_ready_i,
  output logic [31:0] m_req_addr_o,
  output logic [31:0] m_req_wdata_o,
  output logic        m_req_we_o,
  output logic [3:0]  m_req_strb_o,
  input  logic        m_rsp_valid_i,
  input  logic [31:0] m_rsp_data_i,
  input  logic        m_rsp_err_i,
  output logic        busy_o,
  output logic        proto_err_o
);
  localparam int PW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [PW-1:0] LAST = PW'(MAX_OUTSTANDING - 1);
  // per-entry source (1 = LSU) and drop flag, indexed by FIFO slot
  logic [MAX_OUTSTANDING-1:0] src_q, drop_q;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [3:0] starve_cnt;
  logic locked, lock_src;
  logic gnt_l, gnt_valid, empty, full, push, pop, head_src, head_drop;
  assign empty = count == '0;
  assign full = count == CW'(MAX_OUTSTANDING);
  // a stalled grant keeps its source so the bus request cannot change mid-handshake
  assign gnt_l = locked ? lock_src : l_req_valid_i && !(starve_cnt == 4'(STARVE_LIMIT) && f_req_valid_i);
  assign gnt_valid = gnt_l ? l_req_valid_i : f_req_valid_i;
  assign m_req_valid_o = !rst && gnt_valid && !full;
  assign push = m_req_valid_o && m_req_ready_i;
  assign pop = !rst && m_rsp_valid_i && !empty;
  assign head_src = src_q[rd_ptr];
  assign head_drop = drop_q[rd_ptr];
  assign m_req_addr_o = gnt_l ? l_req_addr_i : f_req_addr_i;
  assign m_req_wdata_o = gnt_l ? l_req_wdata_i : '0;
  assign m_req_we_o = gnt_l && l_req_we_i;
  assign m_req_strb_o = gnt_l ? l_req_strb_i : 4'hF;
  assign f_req_ready_o = push && !gnt_l;
  assign l_req_ready_o = push && gnt_l;
  // a flush in the same cycle as a fetch response discards it as well
  assign f_rsp_valid_o = pop && !head_src && !head_drop && !flush_i;
  assign l_rsp_valid_o = pop && head_src && !head_drop;
  assign f_rsp_data_o = m_rsp_data_i;
  assign l_rsp_data_o = m_rsp_data_i;
  assign f_rsp_err_o = m_rsp_err_i;
  assign l_rsp_err_o = m_rsp_err_i;
  assign busy_o = !empty;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      starve_cnt <= '0;
      locked <= 1'b0;
      lock_src <= 1'b0;
      proto_err_o <= 1'b0;
      src_q <= '0;
      drop_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr == LAST ? '0 : wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr == LAST ? '0 : rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
      locked <= m_req_valid_o && !m_req_ready_i;
      lock_src <= gnt_l;
      if (m_rsp_valid_i && empty) proto_err_o <= 1'b1;
      if (push && gnt_l && f_req_valid_i && starve_cnt != 4'(STARVE_LIMIT)) starve_cnt <= starve_cnt + 4'd1;
      else if (push && !gnt_l) starve_cnt <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++)
        if (push && wr_ptr == PW'(i)) begin
          src_q[i] <= gnt_l;
          drop_q[i] <= flush_i && !gnt_l;
        end else if (flush_i && !src_q[i]) drop_q[i] <= 1'b1;
    end
endmodule
